// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits) with overlap
// control, Mealy and registered match outputs and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        LEN_W       = 4,
    parameter int unsigned        CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0001_1011),
    parameter int unsigned        DEF_LEN     = 5,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic               out_q,
    output logic [CNT_W-1:0]   match_count
);

    localparam int unsigned        FILL_W    = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   DEF_LEN_L = (DEF_LEN > MAX_LEN) ? MAX_LEN_L : LEN_W'(DEF_LEN);
    localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    // The oldest of MAX_LEN received bits never reaches the compare window
    // (the incoming bit fills position 0), so only MAX_LEN-1 bits are stored.
    logic [MAX_LEN-2:0] hist;
    logic [FILL_W-1:0]  fill;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;

    logic [MAX_LEN-1:0] window_c;
    logic [MAX_LEN-1:0] mask_c;
    logic               hit_c;
    logic               fill_ok_c;
    logic [LEN_W-1:0]   len_clamp_c;
    logic [FILL_W-1:0]  fill_inc_c;

    logic [MAX_LEN-2:0] hist_n;
    logic [FILL_W-1:0]  fill_n;
    logic [MAX_LEN-1:0] pat_n;
    logic [LEN_W-1:0]   len_n;
    logic               ovl_n;
    logic [CNT_W-1:0]   cnt_n;

    // Masked compare of the newest L bits against the programmed pattern
    always_comb begin
        window_c = {hist, in};
        mask_c   = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask_c[i] = (i < 32'(len));
        end
        hit_c       = (((window_c ^ pat) & mask_c) == '0);
        fill_ok_c   = ((32'(fill) + 32'd1) >= 32'(len));
        len_clamp_c = (32'(cfg_len) > MAX_LEN) ? MAX_LEN_L : cfg_len;
        fill_inc_c  = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
    end

    assign out = in_valid & ~cfg_load & ~rst & (len != '0) & fill_ok_c & hit_c;

    // Next-state for history, fill level, shadow config and counter
    always_comb begin
        hist_n = hist;
        fill_n = fill;
        pat_n  = pat;
        len_n  = len;
        ovl_n  = ovl;
        cnt_n  = match_count;

        if (cfg_load) begin
            pat_n  = cfg_pattern;
            len_n  = len_clamp_c;
            ovl_n  = cfg_overlap;
            hist_n = '0;
            fill_n = '0;
        end else if (in_valid) begin
            hist_n = window_c[MAX_LEN-2:0];
            fill_n = (out && !ovl) ? '0 : fill_inc_c;
        end

        if (cnt_clr) begin
            cnt_n = '0;
        end else if (out && (match_count != CNT_MAX)) begin
            cnt_n = match_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            pat         <= DEF_PATTERN;
            len         <= DEF_LEN_L;
            ovl         <= DEF_OVERLAP;
            out_q       <= 1'b0;
            match_count <= '0;
        end else begin
            hist        <= hist_n;
            fill        <= fill_n;
            pat         <= pat_n;
            len         <= len_n;
            ovl         <= ovl_n;
            out_q       <= out;
            match_count <= cnt_n;
        end
    end

endmodule
